sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port 1RW SRAM macro (32-bit word, 1<<ADDR_W deep) between N_REQ requesters.
//  Round-robin arbitration; at most one access issued per cycle.
//  Read data is routed back to the issuing requester one cycle after acceptance.
//  Owns a clear engine that zero-fills the macro after reset or on demand.
//  Sits between the core/DMA memory clients and the SRAM macro in the local-memory subsystem.
// PARAMETERS
//  N_REQ          4   number of requesters (>=2)
//  ADDR_W         12  SRAM address width; DEPTH = 1<<ADDR_W
//  DATA_W         32  SRAM word width
//  CLEAR_ON_RESET 1   1: zero-fill the macro after reset before serving; 0: serve immediately
// PORTS
//  clk        in   1               single clock; also drives the SRAM macro clock
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   N_REQ           per-requester request valid
//  req_ready  out  N_REQ           per-requester accept; one-hot or zero
//  req_we     in   N_REQ           1 = write, 0 = read
//  req_addr   in   N_REQ*ADDR_W    packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   N_REQ*DATA_W    packed write data
//  rsp_valid  out  1               read data valid (single-cycle pulse)
//  rsp_id     out  $clog2(N_REQ)   index of the requester owning rsp_rdata
//  rsp_rdata  out  DATA_W          read data
//  clear_req  in   1               pulse: start a zero-fill pass
//  init_done  out  1               1 = in SERVE state; 0 while clearing
//  sram_csb   out  1               to macro, active-low chip select
//  sram_web   out  1               to macro, active-low write enable
//  sram_addr  out  ADDR_W          to macro
//  sram_din   out  DATA_W          to macro
//  sram_dout  in   DATA_W          from macro; valid the cycle after a read edge
// BEHAVIOUR
//  Reset values:
//   - FSM = CLEAR if CLEAR_ON_RESET, else SERVE; clear counter = 0; rr pointer = 0.
//   - rsp_valid = 0, rsp_id = 0, rsp_rdata = 0, req_ready = 0.
//   - sram_csb = 1, sram_web = 1; init_done = !CLEAR_ON_RESET.
//  CLEAR:
//   - Each cycle: csb = 0, web = 0, addr = cnt, din = 0; cnt increments.
//   - After writing DEPTH-1, go to SERVE. Exactly DEPTH cycles.
//   - req_ready = 0 throughout; init_done = 0.
//   - clear_req is ignored while in CLEAR.
//  SERVE arbitration:
//   - Grant g = first i with req_valid[i] set, searching from the rr pointer upward with wrap.
//   - req_ready = onehot(g) in the same cycle (combinational from req_valid).
//   - Requesters must not make req_valid depend on req_ready.
//   - Accept = valid & ready. On accept, rr pointer <= (g+1) mod N_REQ; otherwise the pointer holds.
//  SERVE macro drive:
//   - On accept: csb = 0, web = ~req_we[g], addr/din = requester g fields.
//   - With no valid requester: csb = 1, web = 1, addr/din hold 0.
//  Read response:
//   - Read accepted in cycle t -> rsp_valid = 1 and rsp_id = g in cycle t+1.
//   - rsp_rdata = sram_dout when rsp_valid = 1, else 0.
//   - Latency is fixed at 1; no response backpressure. Throughput is one access per cycle.
//   - Writes produce no response.
//  Ordering: a write accepted in cycle t followed by a read of the same address in t+1 returns the
//   new data (the macro commits the write at the t edge).
//  clear_req in SERVE:
//   - The same cycle's request is still arbitrated and issued.
//   - The next state is CLEAR with cnt = 0.
//   - A read issued in that cycle still produces its response in the first CLEAR cycle.
//  Reset mid-CLEAR: cnt restarts at 0; the full DEPTH-cycle pass repeats.
//  Reset with a read in flight: the response is dropped (rsp_valid = 0).
// STRUCTURE
//  - Package kira_mem_pkg: FSM state enum {ST_CLEAR, ST_SERVE}, default ADDR_W/DATA_W,
//    and the $clog2-based ID width function.
//  - Sub-module rr_arbiter:
//    - parameter N, inputs req[N], advance; output gnt one-hot.
//    - Holds the rotating pointer; pointer reset = 0, advances on the advance input.
//  - Top level: FSM, clear counter, request mux, 1-stage response pipe
//    (rd_issued_q, id_q).
// TESTING
//  1. CLEAR_ON_RESET=1; deassert rst -> init_done rises exactly 4096 cycles later, req_ready = 0
//     throughout; then a read of 0xFFF returns 0x00000000.
//  2. Req0 writes 0x123 = 0xDEADBEEF, then reads 0x123 -> rsp_valid one cycle after the read accept,
//     rsp_id = 0, rsp_rdata = 0xDEADBEEF.
//  3. All 4 req_valid held high -> req_ready sequence 0001, 0010, 0100, 1000, 0001; one access per cycle.
//  4. Req1 writes 0x010 = 0xA5A5A5A5 in cycle t; req2 reads 0x010 in t+1 -> t+2 rsp_id = 2,
//     rsp_rdata = 0xA5A5A5A5.
//  5. clear_req in the same cycle as a req3 read of 0x123 -> next cycle rsp_valid = 1, rsp_id = 3,
//     old data; init_done = 0 for 4096 cycles; afterwards 0x123 reads 0.
//  6. Assert rst for 1 cycle when cnt = 100 -> sram_addr restarts at 0; init_done 4096 cycles after
//     rst deasserts.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the local-memory SRAM port arbiter.
package kira_mem_pkg;

    // Top-level operating mode: zero-filling the macro or serving requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    // Width of an index able to name any of n requesters (at least one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: request handshake plus read response.
interface sram_port_arbiter_if
    import kira_mem_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_rdata
    );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter
    import kira_mem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = id_width(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // First requester at or above the pointer (with wrap) wins; pointer moves past it.
    always_comb begin
        int   idx;
        logic found;
        gnt       = '0;
        w_ptr_nxt = r_ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx]  = 1'b1;
                found     = 1'b1;
                w_ptr_nxt = PW'((idx + 1) % N);
            end else begin
                found = found;
            end
        end
    end

    // Pointer register: only rotates when the grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1RW SRAM macro between N_REQ requesters with round-robin arbitration,
// a fixed one-cycle read response and a zero-fill clear engine.
module sram_port_arbiter
    import kira_mem_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus,
    input  logic                 clear_req,
    output logic                 init_done,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_din,
    input  logic [DATA_W-1:0]    sram_dout
);
    localparam int ID_W = id_width(N_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_rd_issued;
    logic [ID_W-1:0]   r_id;

    logic              w_serving;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_accept;
    logic [ID_W-1:0]   w_gid;
    logic              w_g_we;
    logic [ADDR_W-1:0] w_g_addr;
    logic [DATA_W-1:0] w_g_wdata;

    // Requests are only visible to the arbiter while serving and out of reset,
    // so every raised grant is an accepted access.
    assign w_serving = !rst && (r_state == ST_SERVE);

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid & {N_REQ{w_serving}}),
        .advance (w_accept),
        .gnt     (w_gnt)
    );

    assign w_accept      = |w_gnt;
    assign bus.req_ready = w_gnt;

    // Encode the one-hot grant into the winning requester index.
    always_comb begin
        w_gid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gid = ID_W'(i);
            end else begin
                w_gid = w_gid;
            end
        end
    end

    assign w_g_we    = bus.req_we[w_gid];
    assign w_g_addr  = bus.req_addr[int'(w_gid)*ADDR_W +: ADDR_W];
    assign w_g_wdata = bus.req_wdata[int'(w_gid)*DATA_W +: DATA_W];

    // Mode/clear-counter next state and macro drive; the macro is idled while rst is high.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        sram_csb    = 1'b1;
        sram_web    = 1'b1;
        sram_addr   = '0;
        sram_din    = '0;
        if (rst) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    sram_csb  = 1'b0;
                    sram_web  = 1'b0;
                    sram_addr = r_cnt;
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_SERVE;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                    end
                end
                ST_SERVE: begin
                    if (w_accept) begin
                        sram_csb  = 1'b0;
                        sram_web  = ~w_g_we;
                        sram_addr = w_g_addr;
                        sram_din  = w_g_wdata;
                    end else begin
                        sram_csb  = 1'b1;
                    end
                    if (clear_req) begin
                        w_state_nxt = ST_CLEAR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_SERVE;
                    end
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Mode and clear-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // One-stage response pipe: remember that a read went out and who issued it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_issued <= 1'b0;
            r_id        <= '0;
        end else begin
            r_rd_issued <= w_accept && !w_g_we;
            if (w_accept && !w_g_we) begin
                r_id <= w_gid;
            end
        end
    end

    // A response due in a reset cycle is dropped.
    assign bus.rsp_valid = r_rd_issued && !rst;
    assign bus.rsp_id    = rst ? '0 : r_id;
    assign bus.rsp_rdata = (r_rd_issued && !rst) ? sram_dout : '0;
    assign init_done     = rst ? !CLEAR_ON_RESET : (r_state == ST_SERVE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a behavioural model.
module tb_sram_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 4096;

    logic          clk;
    logic          rst;
    logic          clear_req;
    logic          init_done;
    logic          sram_csb;
    logic          sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    sram_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clear_req (clear_req),
        .init_done (init_done),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM macro: write commits at the edge, read data appears after the edge.
    logic [DW-1:0] mac_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mac_mem[sram_addr] <= sram_din;
            else           sram_dout <= mac_mem[sram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            m_known = 1'b0;
    bit            m_clear;
    int            m_cnt;
    int            m_ptr;
    bit            m_pend;
    int            m_pid;
    logic [DW-1:0] m_pdata;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Compare every cycle on the falling edge, then step the model over the coming rising edge.
    always @(negedge clk) begin : cmp
        int            g;
        logic [N-1:0]  e_rdy;
        logic          e_csb, e_web;
        logic [AW-1:0] e_addr, ga;
        logic [DW-1:0] e_din, gd;
        bit            nxt_pend;
        if (rst) begin
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_csb", 32'(sram_csb), 32'd1);
            chk("rst_web", 32'(sram_web), 32'd1);
            chk("rst_init_done", 32'(init_done), 32'd0);
            m_known = 1'b1; m_clear = 1'b1; m_cnt = 0; m_ptr = 0; m_pend = 1'b0;
        end else if (m_known) begin
            e_rdy = '0; e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0; g = -1;
            ga = '0; gd = '0;
            if (m_clear) begin
                e_csb = 1'b0; e_web = 1'b0; e_addr = AW'(m_cnt);
            end else begin
                g = pick(bus.req_valid, m_ptr);
                if (g >= 0) begin
                    ga = bus.req_addr[g*AW +: AW];
                    gd = bus.req_wdata[g*DW +: DW];
                    e_rdy[g] = 1'b1; e_csb = 1'b0; e_web = !bus.req_we[g];
                    e_addr = ga; e_din = gd;
                end
            end
            chk("ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("csb", 32'(sram_csb), 32'(e_csb));
            chk("web", 32'(sram_web), 32'(e_web));
            chk("addr", 32'(sram_addr), 32'(e_addr));
            chk("din", sram_din, e_din);
            chk("init_done", 32'(init_done), 32'(!m_clear));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rsp_id", 32'(bus.rsp_id), 32'(m_pid));
                chk("rsp_rdata", bus.rsp_rdata, m_pdata);
            end else begin
                chk("rsp_rdata_idle", bus.rsp_rdata, 32'd0);
            end
            nxt_pend = 1'b0;
            if (m_clear) begin
                ref_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == DEPTH) m_clear = 1'b0;
            end else begin
                if (g >= 0) begin
                    if (bus.req_we[g]) begin
                        ref_mem[ga] = gd;
                    end else begin
                        nxt_pend = 1'b1; m_pid = g; m_pdata = ref_mem[ga];
                    end
                    m_ptr = (g + 1) % N;
                end
                if (clear_req) begin
                    m_clear = 1'b1; m_cnt = 0;
                end
            end
            m_pend = nxt_pend;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]           = 1'b1;
        bus.req_we[i]              = we;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    logic [N-1:0] seq [0:4];
    int n;
    int bad;

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        rst = 1'b1; clear_req = 1'b0;
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Power-up clear: ready stays low even with every requester asking.
        bus.req_valid = '1;
        n = 0; bad = 0;
        while (!init_done && n < 5000) begin
            if (bus.req_ready != '0) bad++;
            @(posedge clk); #1;
            n++;
        end
        idle();
        chk("t1_init_cycles", 32'(n), 32'd4096);
        chk("t1_ready_low", 32'(bad), 32'd0);
        set_req(0, 1'b0, 12'hFFF, 32'd0); step(); idle();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_rdata", bus.rsp_rdata, 32'h0000_0000);

        // Write then read back through requester 0.
        set_req(0, 1'b1, 12'h123, 32'hDEAD_BEEF); step(); idle();
        set_req(0, 1'b0, 12'h123, 32'd0); step(); idle();
        chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

        // Requester 3 access rotates the pointer back to 0, then all four contend.
        set_req(3, 1'b0, 12'h001, 32'd0); step(); idle();
        bus.req_we = '0;
        bus.req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_ready_seq", 32'(bus.req_ready), 32'(seq[c]));
            step();
        end
        idle();

        // Write by requester 1 followed immediately by a read by requester 2.
        set_req(1, 1'b1, 12'h010, 32'hA5A5_A5A5); step(); idle();
        set_req(2, 1'b0, 12'h010, 32'd0); step(); idle();
        chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t4_rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("t4_rdata", bus.rsp_rdata, 32'hA5A5_A5A5);

        // Clear request together with a read: the read still completes with old data.
        set_req(3, 1'b0, 12'h123, 32'd0); clear_req = 1'b1; step(); idle(); clear_req = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t5_rsp_id", 32'(bus.rsp_id), 32'd3);
        chk("t5_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("t5_init_low", 32'(init_done), 32'd0);
        wait_init(n);
        chk("t5_clear_cycles", 32'(n), 32'd4096);
        set_req(1, 1'b0, 12'h123, 32'd0); step(); idle();
        chk("t5_cleared", bus.rsp_rdata, 32'd0);

        // Reset in the middle of a clear pass restarts the counter.
        clear_req = 1'b1; step(); clear_req = 1'b0;
        n = 0;
        while (sram_addr != 12'd100 && n < 200) begin
            step(); n++;
        end
        chk("t6_reach_100", 32'(sram_addr), 32'd100);
        rst = 1'b1; step(); rst = 1'b0; #1;
        chk("t6_addr_restart", 32'(sram_addr), 32'd0);
        chk("t6_csb", 32'(sram_csb), 32'd0);
        wait_init(n);
        chk("t6_clear_cycles", 32'(n), 32'd4096);

        // Reset while a read response is due drops the response.
        set_req(0, 1'b0, 12'h005, 32'd0); step(); idle();
        rst = 1'b1; #1;
        chk("t7_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        step(); rst = 1'b0;
        wait_init(n);
        chk("t7_clear_cycles", 32'(n), 32'd4096);

        // Random traffic over a small address pool, with one clear pass in the middle.
        for (int c = 0; c < 5600; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i]          = ($urandom_range(0, 2) != 0);
                bus.req_we[i]             = $urandom_range(0, 1) == 1;
                bus.req_addr[i*AW +: AW]  = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom_range(0, 7));
                bus.req_wdata[i*DW +: DW] = $urandom;
            end
            clear_req = (c == 600) || ($urandom_range(0, 999) == 0);
            step();
        end
        idle(); clear_req = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
